// File: rtl/d_mem_pkg.sv
// Shared encodings and write-lane helpers for the d_mem data memory.
package dmem_pkg;

  localparam logic [1:0] OP_EXTRA = 2'b00;
  localparam logic [1:0] OP_SDT   = 2'b01;

  localparam logic [1:0] LD_WORD = 2'b00;
  localparam logic [1:0] LD_UH   = 2'b01;
  localparam logic [1:0] LD_SB   = 2'b10;
  localparam logic [1:0] LD_SH   = 2'b11;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_BYTE = 4'b0001;

  // Unknown byte-enable patterns fall through to a full-word store.
  function automatic logic [3:0] lane_mask(input logic [3:0] be, input logic [1:0] off);
    case (be)
      BE_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      BE_BYTE: lane_mask = 4'b0001 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [3:0] be, input logic [31:0] wd);
    case (be)
      BE_HALF: lane_data = {2{wd[15:0]}};
      BE_BYTE: lane_data = {4{wd[7:0]}};
      default: lane_data = wd;
    endcase
  endfunction

endpackage

// File: rtl/d_mem_if.sv
// Memory-stage access bus for d_mem. There is no handshake: every cycle is one
// access, writes commit on the rising clock edge and rd follows the inputs combinationally.
interface d_mem_if;
  logic        we;
  logic [31:0] a;
  logic [3:0]  be;
  logic [1:0]  op;
  logic [1:0]  op2;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, a, be, op, op2, wd, input rd);
  modport slave  (input we, a, be, op, op2, wd, output rd);
endinterface

// File: rtl/d_mem_load_ext.sv
// Load-side lane select and zero/sign extension for d_mem.
// Sign extension of op2=10/11 is built only when DMEM_SIGNED_LOAD_EN is defined.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] w,
  input  logic [1:0]  off,
  input  logic [3:0]  be,
  input  logic [1:0]  op,
  input  logic [1:0]  op2,
  output logic [31:0] rd
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = w[{off, 3'b000} +: 8];
    half_sel = w[{off[1], 4'b0000} +: 16];
    rd       = w;
    if (op == OP_SDT) begin
      // LDR returns the whole word unrotated even on a misaligned address.
      rd = (be == BE_WORD) ? w : {24'b0, byte_sel};
    end else if (op == OP_EXTRA) begin
      case (op2)
        LD_UH: rd = {16'b0, half_sel};
`ifdef DMEM_SIGNED_LOAD_EN
        LD_SB: rd = {{24{byte_sel[7]}}, byte_sel};
        LD_SH: rd = {{16{half_sel[15]}}, half_sel};
`else
        LD_SB: rd = {24'b0, byte_sel};
        LD_SH: rd = {16'b0, half_sel};
`endif
        default: rd = w;
      endcase
    end
  end

endmodule

// File: rtl/d_mem.sv
// Word-organised data memory with byte-lane-masked stores and async clear.
// Optional signed extra loads: define DMEM_SIGNED_LOAD_EN.
module d_mem
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic    clk,
  input  logic    reset,
  d_mem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [3:0]    mask;
  logic [31:0]   wdata;
  logic [31:0]   w;

  // Address bits above the word index are ignored, so accesses wrap.
  assign idx = bus.a[2 +: AW];
  assign w   = mem[idx];

  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.a[31:2+AW];

  always_comb begin
    mask  = lane_mask(bus.be, bus.a[1:0]);
    wdata = lane_data(bus.be, bus.wd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.we) begin
      for (int l = 0; l < 4; l++) begin
        if (mask[l]) mem[idx][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  dmem_load_ext u_load_ext (
    .w   (w),
    .off (bus.a[1:0]),
    .be  (bus.be),
    .op  (bus.op),
    .op2 (bus.op2),
    .rd  (bus.rd)
  );

endmodule

// File: tb/tb_d_mem.sv
// Self-checking bench for d_mem: directed scenarios plus randomized traffic
// against a byte-array reference model.
module tb_d_mem;

  localparam int DEPTH = 64;

  logic clk;
  logic reset;

  d_mem_if bus ();

  d_mem #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [DEPTH*4];
  logic [31:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  function automatic int word_base(input logic [31:0] addr);
    return ((addr / 4) % DEPTH) * 4;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [3:0] be_i, input logic [31:0] wd_i);
    int base;
    int off;
    base = word_base(addr);
    off  = addr % 4;
    if (be_i == 4'b0001) begin
      ref_mem[base + off] = wd_i[7:0];
    end else if (be_i == 4'b0011) begin
      ref_mem[base + (off / 2) * 2]     = wd_i[7:0];
      ref_mem[base + (off / 2) * 2 + 1] = wd_i[15:8];
    end else begin
      for (int k = 0; k < 4; k++) ref_mem[base + k] = 8'((wd_i >> (8 * k)) & 32'hFF);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [1:0] op_i,
                                             input logic [1:0] op2_i, input logic [3:0] be_i);
    int base;
    int off;
    logic [31:0] word;
    logic [31:0] b;
    logic [31:0] h;
    base = word_base(addr);
    off  = addr % 4;
    word = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    b    = {24'b0, ref_mem[base + off]};
    h    = {16'b0, ref_mem[base + (off / 2) * 2 + 1], ref_mem[base + (off / 2) * 2]};
    if (op_i >= 2) return word;
    if (op_i == 1) return (be_i == 4'b1111) ? word : b;
    case (op2_i)
      2'd1: return h;
`ifdef DMEM_SIGNED_LOAD_EN
      2'd2: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      2'd3: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
`else
      2'd2: return b;
      2'd3: return h;
`endif
      default: return word;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_read(input logic [31:0] addr, input logic [1:0] op_i,
                          input logic [1:0] op2_i, input logic [3:0] be_i);
    bus.we  = 1'b0;
    bus.a   = addr;
    bus.op  = op_i;
    bus.op2 = op2_i;
    bus.be  = be_i;
    #1;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [1:0] op_i,
                            input logic [1:0] op2_i, input logic [3:0] be_i, input logic [31:0] exp);
    set_read(addr, op_i, op2_i, be_i);
    exp_q.push_back(exp);
    check(tag, bus.rd, exp_q.pop_front());
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] be_i,
                          input logic [31:0] wd_i, input logic we_i);
    bus.a  = addr;
    bus.be = be_i;
    bus.wd = wd_i;
    bus.we = we_i;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    if (we_i && !reset) model_write(addr, be_i, wd_i);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra;
    logic [3:0]  rbe;
    logic [1:0]  rop;
    logic [1:0]  rop2;
    logic [31:0] rwd;
    logic        rwe;
    logic [3:0]  be_tab [4];

    be_tab[0] = 4'b1111;
    be_tab[1] = 4'b0011;
    be_tab[2] = 4'b0001;
    be_tab[3] = 4'b0110;

    reset   = 1'b1;
    bus.we  = 1'b0;
    bus.a   = '0;
    bus.be  = 4'b1111;
    bus.op  = 2'b01;
    bus.op2 = 2'b00;
    bus.wd  = '0;
    model_clear();

    read_check("reset_a0",   32'd0,   2'b01, 2'b00, 4'b1111, 32'h0);
    read_check("reset_a40",  32'd40,  2'b01, 2'b00, 4'b1111, 32'h0);
    read_check("reset_a252", 32'd252, 2'b01, 2'b00, 4'b1111, 32'h0);

    // write during reset is dropped
    do_write(32'd8, 4'b1111, 32'hCAFE_F00D, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    read_check("write_in_reset_dropped", 32'd8, 2'b10, 2'b00, 4'b1111, 32'h0);

    do_write(32'd63, 4'b1111, 32'd1000000, 1'b1);
    read_check("word_load", 32'd63, 2'b01, 2'b00, 4'b1111, 32'h000F_4240);

    do_write(32'd40, 4'b0011, 32'h1234_8001, 1'b1);
    read_check("half_raw", 32'd40, 2'b10, 2'b00, 4'b1111, 32'h0000_8001);
`ifdef DMEM_SIGNED_LOAD_EN
    read_check("half_sh", 32'd40, 2'b00, 2'b11, 4'b0011, 32'hFFFF_8001);
`else
    read_check("half_sh", 32'd40, 2'b00, 2'b11, 4'b0011, 32'h0000_8001);
`endif
    read_check("half_uh", 32'd40, 2'b00, 2'b01, 4'b0011, 32'h0000_8001);

    do_write(32'd41, 4'b0001, 32'h0000_00FF, 1'b1);
    read_check("byte_raw", 32'd40, 2'b00, 2'b00, 4'b1111, 32'h0000_FF01);
`ifdef DMEM_SIGNED_LOAD_EN
    read_check("byte_sb", 32'd41, 2'b00, 2'b10, 4'b0001, 32'hFFFF_FFFF);
`else
    read_check("byte_sb", 32'd41, 2'b00, 2'b10, 4'b0001, 32'h0000_00FF);
`endif
    read_check("byte_ldrb", 32'd41, 2'b01, 2'b00, 4'b0001, 32'h0000_00FF);

    read_check("off3_sb", 32'd63, 2'b00, 2'b10, 4'b0001, 32'h0000_0000);
    read_check("off3_sh", 32'd63, 2'b00, 2'b11, 4'b0011, 32'h0000_000F);

    do_write(32'd0, 4'b1111, 32'hDEAD_BEEF, 1'b0);
    read_check("we0_no_write", 32'd0, 2'b11, 2'b00, 4'b1111, 32'h0);
    do_write(32'd256, 4'b1111, 32'd5, 1'b1);
    read_check("wrap_write", 32'd0, 2'b01, 2'b00, 4'b1111, 32'd5);

    pulse_reset();
    read_check("midrun_reset_a60", 32'd60, 2'b01, 2'b00, 4'b1111, 32'h0);
    read_check("midrun_reset_a0",  32'd0,  2'b01, 2'b00, 4'b1111, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    do_write(32'd60, 4'b1111, 32'h0BAD_F00D, 1'b1);
    read_check("post_reset_write", 32'd60, 2'b01, 2'b00, 4'b1111, 32'h0BAD_F00D);

    // randomized traffic: check old contents before each edge, then commit
    for (int n = 0; n < 400; n++) begin
      ra   = $urandom_range(0, 1023);
      rbe  = be_tab[$urandom_range(0, 3)];
      rop  = 2'($urandom_range(0, 3));
      rop2 = 2'($urandom_range(0, 3));
      rwd  = $urandom;
      rwe  = ($urandom_range(0, 3) != 0);
      set_read(ra, rop, rop2, rbe);
      bus.wd = rwd;
      bus.we = rwe;
      #1;
      check("rand_read", bus.rd, model_read(ra, rop, rop2, rbe));
      do_write(ra, rbe, rwd, rwe);
      set_read(ra, rop, rop2, rbe);
      check("rand_after_edge", bus.rd, model_read(ra, rop, rop2, rbe));
      if ($urandom_range(0, 49) == 0) begin
        pulse_reset();
        check("rand_reset", bus.rd, 32'h0);
        @(negedge clk);
        reset = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
